// File: rtl/shift_pkg.sv
// Shared encodings for the serialiser and the downstream universal shift-register datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'b00,
    SH_LEFT  = 2'b01,
    SH_RIGHT = 2'b10,
    SH_LOAD  = 2'b11
  } shift_ctrl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } tx_state_t;

endpackage

// File: rtl/piso_frame_tx_bit_timer.sv
// Bit-time divider: counts DIV clocks per serial bit and strobes tick on the last one.
module piso_bit_timer #(
  parameter int DIV = 4,
  parameter int DW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  assign tick = en && (div_cnt_q == LAST);

  // Wraps to zero on the terminal clock so the next bit (or gap) starts aligned.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter with valid/ready intake, bit divider and idle gap.
module piso_frame_tx
  import shift_pkg::*;
#(
  parameter int   N        = 8,
  parameter int   DIV      = 4,
  parameter int   GAP_BITS = 1,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  input  logic         s_msb_first,
  output logic         ser_out,
  output logic         ser_en,
  output logic [1:0]   ctrl,
  output logic         busy,
  output logic         done,
  output tx_state_t    dbg_state
);

  // Handshake: a word transfers on a rising edge where s_valid && s_ready;
  // s_ready is high only in IDLE and s_valid is ignored everywhere else.

  localparam int BW = $clog2(N);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_t   state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic          msb_q, msb_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_en_q, ser_en_d;
  shift_ctrl_t   ctrl_q, ctrl_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          s_ready_q, s_ready_d;
  logic          accept;
  logic          tick;

  piso_bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    msb_d     = msb_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ser_out_d = ser_out_q;
    ser_en_d  = ser_en_q;
    ctrl_d    = SH_HOLD;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_ready_d = s_ready_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready_q) begin
          accept    = 1'b1;
          sreg_d    = s_data;
          msb_d     = s_msb_first;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          ctrl_d    = SH_LOAD;
          ser_out_d = s_msb_first ? s_data[N-1] : s_data[0];
          ser_en_d  = 1'b1;
          busy_d    = 1'b1;
          s_ready_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            done_d    = 1'b1;
            ser_out_d = IDLE_LVL;
            ser_en_d  = 1'b0;
            if (GAP_BITS > 0) begin
              state_d = GAP;
            end else begin
              busy_d    = 1'b0;
              s_ready_d = 1'b1;
              state_d   = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // ser_out takes the bit that lands at the output end after this shift.
            if (msb_q) begin
              sreg_d    = {sreg_q[N-2:0], 1'b0};
              ser_out_d = sreg_q[N-2];
              ctrl_d    = SH_LEFT;
            end else begin
              sreg_d    = {1'b0, sreg_q[N-1:1]};
              ser_out_d = sreg_q[1];
              ctrl_d    = SH_RIGHT;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            busy_d    = 1'b0;
            s_ready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      msb_q     <= 1'b0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ser_out_q <= IDLE_LVL;
      ser_en_q  <= 1'b0;
      ctrl_q    <= SH_HOLD;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      msb_q     <= msb_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ser_out_q <= ser_out_d;
      ser_en_q  <= ser_en_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign ser_out   = ser_out_q;
  assign ser_en    = ser_en_q;
  assign ctrl      = ctrl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench: DUT a uses N=8/DIV=4/GAP=1, DUT b uses N=8/DIV=1/GAP=0.
module tb_piso_frame_tx;

  localparam int N = 8;
  localparam int A_DIV = 4;
  localparam int A_GAP = 1;
  localparam int B_DIV = 1;
  localparam int B_GAP = 0;

  logic clk = 1'b0;
  logic reset;

  logic         a_s_valid, a_s_ready, a_s_msb_first, a_ser_out, a_ser_en, a_busy, a_done;
  logic [N-1:0] a_s_data;
  logic [1:0]   a_ctrl, a_state;
  logic         b_s_valid, b_s_ready, b_s_msb_first, b_ser_out, b_ser_en, b_busy, b_done;
  logic [N-1:0] b_s_data;
  logic [1:0]   b_ctrl, b_state;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  piso_frame_tx #(.N(N), .DIV(A_DIV), .GAP_BITS(A_GAP), .IDLE_LVL(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .s_msb_first(a_s_msb_first), .ser_out(a_ser_out), .ser_en(a_ser_en), .ctrl(a_ctrl),
    .busy(a_busy), .done(a_done), .dbg_state(a_state)
  );

  piso_frame_tx #(.N(N), .DIV(B_DIV), .GAP_BITS(B_GAP), .IDLE_LVL(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_msb_first(b_s_msb_first), .ser_out(b_ser_out), .ser_en(b_ser_en), .ctrl(b_ctrl),
    .busy(b_busy), .done(b_done), .dbg_state(b_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed vector order: {ser_out, ser_en, done, ctrl[1:0], s_ready, busy}
  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1;
    a_s_valid = 1'b0; a_s_data = '0; a_s_msb_first = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_msb_first = 1'b1;
    repeat (3) step();
    obs = {a_ser_out, a_ser_en, a_done, a_ctrl, a_s_ready, a_busy};
    checks++;
    if (obs !== 7'b1_0_0_00_1_0) $display("FAIL reset_a: got %b expected 1000010", obs);
    else passed++;
    obs = {b_ser_out, b_ser_en, b_done, b_ctrl, b_s_ready, b_busy};
    checks++;
    if (obs !== 7'b1_0_0_00_1_0) $display("FAIL reset_b: got %b expected 1000010", obs);
    else passed++;
    checks++;
    if (a_state !== 2'b00) $display("FAIL reset_state: got %b expected 00", a_state);
    else passed++;
    reset = 1'b0;
    step();
  endtask

  // Waits (bounded) for s_ready, transfers one word, then checks every cycle of
  // the frame up to and including the cycle where s_ready comes back.
  task automatic send_watch_a(input logic [N-1:0] data, input logic msb,
                              input logic scramble, input string name);
    int waited = 0;
    int loads = 0;
    int b;
    logic [6:0] obs, exp_v;
    logic e_ser;
    logic [1:0] e_ctrl;
    while (a_s_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    checks++;
    if (a_s_ready !== 1'b1) begin
      $display("FAIL %s_ready_timeout: got s_ready=%b expected 1 within 100 cycles", name, a_s_ready);
      return;
    end
    passed++;
    a_s_valid = 1'b1; a_s_data = data; a_s_msb_first = msb;
    step();
    a_s_valid = 1'b0;
    for (int c = 0; c <= (N + A_GAP) * A_DIV; c++) begin
      b = c / A_DIV;
      if (c < N * A_DIV) e_ser = msb ? data[N-1-b] : data[b];
      else e_ser = 1'b1;
      if (c == 0) e_ctrl = 2'b11;
      else if (c < N * A_DIV && (c % A_DIV) == 0) e_ctrl = msb ? 2'b01 : 2'b10;
      else e_ctrl = 2'b00;
      exp_v = {e_ser, (c < N * A_DIV), (c == N * A_DIV), e_ctrl,
               (c >= (N + A_GAP) * A_DIV), (c < (N + A_GAP) * A_DIV)};
      obs = {a_ser_out, a_ser_en, a_done, a_ctrl, a_s_ready, a_busy};
      if (a_ctrl === 2'b11) loads++;
      checks++;
      if (obs !== exp_v) $display("FAIL %s_cycle%0d: got %b expected %b", name, c, obs, exp_v);
      else passed++;
      if (scramble) begin
        a_s_data = N'($urandom_range(0, 255));
        a_s_msb_first = 1'($urandom_range(0, 1));
      end
      if (c < (N + A_GAP) * A_DIV) step();
    end
    checks++;
    if (loads !== 1) $display("FAIL %s_load_count: got %0d expected 1", name, loads);
    else passed++;
  endtask

  task automatic test_msb_first();
    send_watch_a(8'hA5, 1'b1, 1'b0, "msb_a5");
  endtask

  task automatic test_lsb_first();
    send_watch_a(8'hA5, 1'b0, 1'b0, "lsb_a5");
    send_watch_a(8'h01, 1'b0, 1'b0, "lsb_01");
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs, exp_v;
    logic [N-1:0] word;
    int c;
    int en_low = 0;
    b_s_valid = 1'b1; b_s_data = 8'hFF; b_s_msb_first = 1'b1;
    step();
    b_s_data = 8'h00;
    for (int t = 0; t <= 17; t++) begin
      c = (t < 9) ? t : t - 9;
      word = (t < 9) ? 8'hFF : 8'h00;
      if (t == 9) b_s_valid = 1'b0;
      exp_v = {(c < 8) ? word[7-c] : 1'b1, (c < 8), (c == 8),
               (c == 0) ? 2'b11 : ((c < 8) ? 2'b01 : 2'b00), (c == 8), (c < 8)};
      obs = {b_ser_out, b_ser_en, b_done, b_ctrl, b_s_ready, b_busy};
      if (t > 0 && t < 17 && b_ser_en === 1'b0) en_low++;
      checks++;
      if (obs !== exp_v) $display("FAIL b2b_t%0d: got %b expected %b", t, obs, exp_v);
      else passed++;
      if (t < 17) step();
    end
    checks++;
    if (en_low !== 1) $display("FAIL b2b_gap_cycles: got %0d expected 1", en_low);
    else passed++;
    // No third word was offered, so the block must stay idle.
    step();
    checks++;
    if (b_busy !== 1'b0 || b_s_ready !== 1'b1) $display("FAIL b2b_idle_after: got busy=%b ready=%b expected 0 1", b_busy, b_s_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [6:0] obs;
    a_s_valid = 1'b1; a_s_data = 8'h3C; a_s_msb_first = 1'b1;
    step();
    a_s_valid = 1'b0;
    repeat (13) step();
    checks++;
    if ({a_ser_out, a_ser_en, a_busy} !== 3'b111) $display("FAIL rst_mid_bit3: got %b expected 111", {a_ser_out, a_ser_en, a_busy});
    else passed++;
    reset = 1'b1;
    step();
    obs = {a_ser_out, a_ser_en, a_done, a_ctrl, a_s_ready, a_busy};
    checks++;
    if (obs !== 7'b1_0_0_00_1_0) $display("FAIL rst_mid_abort: got %b expected 1000010", obs);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_done !== 1'b0 || a_busy !== 1'b0) $display("FAIL rst_mid_quiet%0d: got done=%b busy=%b expected 0 0", i, a_done, a_busy);
      else passed++;
    end
    send_watch_a(8'hC3, 1'b1, 1'b0, "after_rst_c3");
  endtask

  task automatic test_input_change_busy();
    send_watch_a(8'h96, 1'b1, 1'b1, "scramble_96");
    send_watch_a(8'h5A, 1'b0, 1'b1, "scramble_5a");
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_frame();
    test_input_change_busy();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
